// File: rtl/knight_anim_ctrl.sv
// rtl/knight_anim_ctrl.sv - Knight sprite animation sequencer (set/frame/mirror/visibility/attack/death)
// Define KNIGHT_HURT_BLINK_EN to blink Sprite_Visible for BLINK_TICKS after a hurt event.
module knight_anim_ctrl #(
  parameter int FRAME_DIV     = 6,
  parameter int IDLE_FRAMES   = 4,
  parameter int WALK_FRAMES   = 6,
  parameter int AIR_FRAMES    = 2,
  parameter int ATTACK_FRAMES = 5,
  parameter int DEATH_FRAMES  = 8,
  parameter int BLINK_TICKS   = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  input  logic [3:0] Player_Life,
  output logic [2:0] Sprite_Set,
  output logic [3:0] Sprite_Frame,
  output logic       Sprite_Mirror,
  output logic       Sprite_Visible,
  output logic       Attack_Active,
  output logic       Anim_Done,
  output logic       Dead
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_JUMP   = 3'd2,
    S_FALL   = 3'd3,
    S_ATTACK = 3'd4,
    S_DEATH  = 3'd5
  } state_e;

  localparam logic [5:0] DIV_LAST = 6'(FRAME_DIV - 1);

  if (FRAME_DIV < 1 || FRAME_DIV > 63 || IDLE_FRAMES < 1 || IDLE_FRAMES > 15 ||
      WALK_FRAMES < 1 || WALK_FRAMES > 15 || AIR_FRAMES < 1 || AIR_FRAMES > 15 ||
      ATTACK_FRAMES < 3 || ATTACK_FRAMES > 15 || DEATH_FRAMES < 1 || DEATH_FRAMES > 15 ||
      BLINK_TICKS < 1 || BLINK_TICKS > 127) begin : g_param_check
    $error("knight_anim_ctrl: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [5:0] div_q, div_d;
  logic [3:0] frame_q, frame_d;
  logic       mirror_q, mirror_d;
  logic       visible_q, visible_d;
  logic       attack_q, attack_d;
  logic       done_q, done_d;
  logic       dead_q, dead_d;
  logic       death_held_q, death_held_d;

  logic [3:0] last_frame;
  logic       div_wrap;
  logic       frame_last;
  state_e     req_state;

  function automatic state_e status_to_state(input logic [3:0] status);
    case (status)
      4'd1:    return S_WALK;
      4'd2:    return S_JUMP;
      4'd3:    return S_FALL;
      4'd4:    return S_ATTACK;
      default: return S_IDLE;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_WALK:         last_frame = 4'(WALK_FRAMES - 1);
      S_JUMP, S_FALL: last_frame = 4'(AIR_FRAMES - 1);
      S_ATTACK:       last_frame = 4'(ATTACK_FRAMES - 1);
      S_DEATH:        last_frame = 4'(DEATH_FRAMES - 1);
      default:        last_frame = 4'(IDLE_FRAMES - 1);
    endcase
  end

  assign div_wrap   = (div_q == DIV_LAST);
  assign frame_last = (frame_q == last_frame);
  assign req_state  = status_to_state(Player_Status);

  always_comb begin
    state_d      = state_q;
    div_d        = div_wrap ? 6'd0 : div_q + 6'd1;
    frame_d      = frame_q;
    mirror_d     = Inverse;
    done_d       = 1'b0;
    death_held_d = death_held_q;
    if (div_wrap) begin
      frame_d = frame_last ? 4'd0 : frame_q + 4'd1;
    end

    // Losing the last life wins over everything, including the attack lock.
    if (Player_Life == 4'd0) begin
      mirror_d = 1'b0;
      if (state_q != S_DEATH) begin
        state_d      = S_DEATH;
        div_d        = '0;
        frame_d      = '0;
        death_held_d = 1'b0;
      end else if (death_held_q) begin
        div_d   = '0;
        frame_d = frame_q;
      end else if (div_wrap && frame_last) begin
        div_d        = '0;
        frame_d      = frame_q;
        done_d       = 1'b1;
        death_held_d = 1'b1;
      end
    end else if (state_q == S_DEATH) begin
      state_d = S_IDLE;
      div_d   = '0;
      frame_d = '0;
    end else if (state_q == S_ATTACK) begin
      mirror_d = mirror_q;
      if (div_wrap && frame_last) begin
        done_d   = 1'b1;
        state_d  = req_state;
        div_d    = '0;
        frame_d  = '0;
        mirror_d = Inverse;
      end
    end else if (req_state != state_q) begin
      state_d = req_state;
      div_d   = '0;
      frame_d = '0;
    end

    attack_d = (state_d == S_ATTACK) && (frame_d == 4'd2 || frame_d == 4'd3);
    dead_d   = (state_d == S_DEATH);
  end

`ifdef KNIGHT_HURT_BLINK_EN
  logic [3:0] prev_life_q;
  logic [6:0] blink_q, blink_d;
  logic       hurt;

  assign hurt = (Player_Life < prev_life_q) && (Player_Life != 4'd0);

  always_comb begin
    blink_d = blink_q;
    if (state_d == S_DEATH) begin
      blink_d = '0;
    end else if (hurt) begin
      blink_d = 7'(BLINK_TICKS);
    end else if (blink_q != '0) begin
      blink_d = blink_q - 7'd1;
    end
    // Bit 2 toggles every 4 ticks while counting down.
    visible_d = (blink_d == '0) ? 1'b1 : ~blink_d[2];
  end
`else
  assign visible_d = 1'b1;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      frame_q      <= '0;
      mirror_q     <= 1'b0;
      visible_q    <= 1'b1;
      attack_q     <= 1'b0;
      done_q       <= 1'b0;
      dead_q       <= 1'b0;
      death_held_q <= 1'b0;
`ifdef KNIGHT_HURT_BLINK_EN
      prev_life_q  <= '0;
      blink_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      frame_q      <= frame_d;
      mirror_q     <= mirror_d;
      visible_q    <= visible_d;
      attack_q     <= attack_d;
      done_q       <= done_d;
      dead_q       <= dead_d;
      death_held_q <= death_held_d;
`ifdef KNIGHT_HURT_BLINK_EN
      prev_life_q  <= Player_Life;
      blink_q      <= blink_d;
`endif
    end
  end

  assign Sprite_Set     = state_q;
  assign Sprite_Frame   = frame_q;
  assign Sprite_Mirror  = mirror_q;
  assign Sprite_Visible = visible_q;
  assign Attack_Active  = attack_q;
  assign Anim_Done      = done_q;
  assign Dead           = dead_q;

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// tb/tb_knight_anim_ctrl.sv - scoreboard bench for knight_anim_ctrl
// Expected blink pattern follows KNIGHT_HURT_BLINK_EN when it is defined.
module tb_knight_anim_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [3:0] status;
  logic       inv;
  logic [3:0] life;
  logic [2:0] Sprite_Set;
  logic [3:0] Sprite_Frame;
  logic       Sprite_Mirror, Sprite_Visible, Attack_Active, Anim_Done, Dead;

  knight_anim_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .Player_Status  (status),
    .Inverse        (inv),
    .Player_Life    (life),
    .Sprite_Set     (Sprite_Set),
    .Sprite_Frame   (Sprite_Frame),
    .Sprite_Mirror  (Sprite_Mirror),
    .Sprite_Visible (Sprite_Visible),
    .Attack_Active  (Attack_Active),
    .Anim_Done      (Anim_Done),
    .Dead           (Dead)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int          tag;
    string       name;
    logic [11:0] v;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    hurt_j = -1;
  string phase = "none";

  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic logic exp_vis();
`ifdef KNIGHT_HURT_BLINK_EN
    logic [6:0] c;
    if (hurt_j < 0 || hurt_j >= 60) return 1'b1;
    c = 7'(60 - hurt_j);
    return ~c[2];
`else
    return 1'b1;
`endif
  endfunction

  // Drive one tick of inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic [3:0] st, input logic iv, input logic [3:0] lf,
                      input logic [2:0] eset, input int efr, input logic emir,
                      input logic eact, input logic edone, input logic edead);
    exp_t e;
    status = st;
    inv    = iv;
    life   = lf;
    e.tag  = cyc + 1;
    e.name = phase;
    e.v    = {eset, 4'(efr), emir, exp_vis(), eact, edone, edead};
    sb.push_back(e);
    if (hurt_j >= 0) hurt_j++;
    @(negedge frame_clk);
  endtask

  always @(negedge frame_clk) begin
    while (sb.size() != 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.tag != cyc ||
          mon_e.v != {Sprite_Set, Sprite_Frame, Sprite_Mirror, Sprite_Visible,
                      Attack_Active, Anim_Done, Dead}) begin
        errors++;
        $display("FAIL %s cyc=%0d got set=%0d frame=%0d mir=%0b vis=%0b act=%0b done=%0b dead=%0b expected set=%0d frame=%0d mir=%0b vis=%0b act=%0b done=%0b dead=%0b (tag %0d)",
                 mon_e.name, cyc, Sprite_Set, Sprite_Frame, Sprite_Mirror, Sprite_Visible,
                 Attack_Active, Anim_Done, Dead, mon_e.v[11:9], mon_e.v[8:5], mon_e.v[4],
                 mon_e.v[3], mon_e.v[2], mon_e.v[1], mon_e.v[0], mon_e.tag);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    Reset  = 1'b1;
    status = 4'd0;
    inv    = 1'b0;
    life   = 4'd2;
    @(negedge frame_clk);
    phase = "reset";
    tick(0, 0, 2, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;

    phase = "idle_loop";
    for (int i = 1; i <= 26; i++) tick(0, 0, 2, 0, (i / 6) % 4, 0, 0, 0, 0);
    phase = "walk_entry";
    tick(1, 0, 2, 1, 0, 0, 0, 0, 0);
    phase = "walk_loop";
    for (int i = 1; i <= 8; i++) tick(1, 0, 2, 1, (i / 6) % 6, 0, 0, 0, 0);

    phase = "attack_entry";
    tick(4, 1, 2, 4, 0, 1, 0, 0, 0);
    phase = "attack_swing";
    for (int i = 1; i < 30; i++) tick(0, 0, 2, 4, i / 6, 1, (i / 6 == 2 || i / 6 == 3), 0, 0);
    phase = "attack_done";
    tick(0, 0, 2, 0, 0, 0, 0, 1, 0);
    phase = "idle_after";
    for (int i = 1; i <= 3; i++) tick(0, 0, 2, 0, 0, 0, 0, 0, 0);

    phase = "hurt_blink";
    hurt_j = 0;
    for (int i = 4; i <= 69; i++) tick(0, 0, 1, 0, (i / 6) % 4, 0, 0, 0, 0);

    phase = "attack2";
    for (int i = 0; i < 30; i++) tick(4, 0, 1, 4, i / 6, 0, (i / 6 == 2 || i / 6 == 3), 0, 0);
    phase = "reattack";
    tick(4, 0, 1, 4, 0, 0, 0, 1, 0);
    phase = "attack_lock";
    for (int i = 1; i <= 9; i++) tick(2, 0, 1, 4, i / 6, 0, 0, 0, 0);

    phase = "death_entry";
    tick(2, 1, 0, 5, 0, 0, 0, 0, 1);
    phase = "death_play";
    for (int d = 1; d < 48; d++) tick(4, 1, 0, 5, d / 6, 0, 0, 0, 1);
    phase = "death_done";
    tick(4, 1, 0, 5, 7, 0, 0, 1, 1);
    phase = "death_hold";
    for (int d = 49; d <= 56; d++) tick(4, 1, 0, 5, 7, 0, 0, 0, 1);

    #1 Reset = 1'b1;
    hurt_j = -1;
    phase = "reset_mid_death";
    tick(0, 0, 3, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    phase = "idle2";
    for (int i = 1; i <= 2; i++) tick(0, 0, 3, 0, 0, 0, 0, 0, 0);
    phase = "death2";
    for (int d = 0; d < 3; d++) tick(1, 0, 0, 5, 0, 0, 0, 0, 1);
    phase = "revive_idle";
    tick(1, 0, 3, 0, 0, 0, 0, 0, 0);
    phase = "walk2";
    tick(1, 0, 3, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 3, 1, 0, 0, 0, 0, 0);
    phase = "status_alias";
    tick(9, 0, 3, 0, 0, 0, 0, 0, 0);
    tick(9, 0, 3, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge frame_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
